jtbubl_rom_arb: RTL
===================

JTBUBL_ROM_ARB -- requirements
Module: jtbubl_rom_arb

Interface
REQ-001 SUB_OFFSET, 22'h02_0000, SDRAM word offset added to sub CPU ROM word address.
REQ-002 MCU_OFFSET, 22'h02_4000, SDRAM word offset added to MCU ROM word address.
REQ-003 clk24  in  1  single system clock; all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 downloading  in  1  ROM load in progress; arbiter idles and caches invalidate.
REQ-006 main_rom_addr  in  18 / main_rom_cs  in  1 / main_rom_ok  out  1 / main_rom_data  out  8  main CPU byte port.
REQ-007 sub_rom_addr  in  15 / sub_rom_cs  in  1 / sub_rom_ok  out  1 / sub_rom_data  out  8  sub CPU byte port.
REQ-008 mcu_rom_addr  in  12 / mcu_rom_cs  in  1 / mcu_rom_ok  out  1 / mcu_rom_data  out  8  MCU byte port.
REQ-009 sdram_addr  out  22  SDRAM word address; sdram_req  out  1  request; sdram_ack  in  1  request accepted; sdram_dok  in  1  read data valid; sdram_data  in  16  read word.

Function
REQ-010 Responder side of the rom_cs/rom_ok handshake: requester holds cs and addr; block returns data and raises ok.
REQ-011 Each port has one-entry cache: valid bit, tag = full byte address, 8-bit data register.
REQ-012 Hit = cs && valid && tag==addr; rom_ok = hit, combinational, so ok drops in the same cycle addr changes or cs falls.
REQ-013 rom_data = cache data register, held until that port's next fill, regardless of ok.
REQ-014 Miss = cs && !hit && !downloading.
REQ-015 Word address: main {5'd0, addr[17:1]}; sub {8'd0, addr[14:1]} + SUB_OFFSET; mcu {11'd0, addr[11:1]} + MCU_OFFSET; sums modulo 2^22 (wrap, no carry out).
REQ-016 Byte select: addr[0]=0 -> sdram_data[7:0], addr[0]=1 -> sdram_data[15:8].
REQ-017 FSM states IDLE, WAIT_ACK, WAIT_DATA.
REQ-018 IDLE: if any miss, choose port by round-robin (order main->sub->mcu, search starts after last served port), latch port id and byte address, drive sdram_addr, set sdram_req=1 next cycle, go WAIT_ACK; otherwise stay.
REQ-019 WAIT_ACK: hold sdram_req and sdram_addr stable until sdram_ack=1; clear sdram_req on the cycle after ack seen, go WAIT_DATA. If ack and dok arrive in the same cycle, treat as ack then dok: fill and go IDLE.
REQ-020 WAIT_DATA: on sdram_dok=1 write selected byte into latched port's cache, tag=latched address, valid=1, update round-robin pointer, go IDLE.
REQ-021 Minimum latency: miss visible cycle N -> req high N+1 -> ack N+1 -> dok N+2 -> ok high N+3.
REQ-022 Requester changes addr or drops cs mid-fetch: fetch completes, cache filled with latched address; no abort; new address served as a later miss.
REQ-023 Only one outstanding SDRAM request; other misses wait with ok low.
REQ-024 downloading=1: all valid bits clear every cycle, no new request issued; an in-flight request completes its handshake but fill is discarded (valid stays 0).
REQ-025 Round-robin guarantees each pending port is served within 3 fetches.

Reset
REQ-026 rst=1 asynchronously: state IDLE, sdram_req=0, sdram_addr=0, all valid=0, all rom_ok=0, all rom_data=8'h00, round-robin pointer = mcu (main first next).
REQ-027 Reset mid-handshake abandons fetch; any late sdram_ack/dok after release is ignored in IDLE.

Verification
REQ-028 main_rom_cs=1 addr=18'h00005, SDRAM ack 1 cycle, dok 2 cycles later with 16'hBEEF -> sdram_addr=22'h000002, main_rom_data=8'hBE, main_rom_ok=1 until addr changes.
REQ-029 Main, sub, mcu all miss simultaneously -> served main, sub, mcu in that order, exactly three req pulses, each ok rises only after own fill.
REQ-030 sub_rom_addr=15'h7FFF with SUB_OFFSET=22'h3F_FFFF -> sdram_addr=22'h003FFE (wrap), low/high byte select correct.
REQ-031 Main changes addr from 18'h00010 to 18'h00020 during WAIT_DATA -> ok stays low, second request to word 22'h000010 issued after fill.
REQ-032 downloading asserted with all caches valid -> all ok drop next cycle, no sdram_req while high; rst pulse mid-WAIT_ACK -> req=0 immediately, state IDLE.

Source files
------------

// File: rtl/jtbubl_rom_arb.sv
// jtbubl_rom_arb
//   Arbitrates three byte-wide ROM readers (main CPU, sub CPU, MCU) onto one
//   16-bit SDRAM read port. Each reader has a one-entry cache. rom_ok is a
//   combinational hit, so it drops as soon as the address changes or cs falls.
//   Misses are served one at a time, in round-robin order.
//
// Ports
//   clk24, rst          system clock, asynchronous active-high reset
//   downloading         ROM load in progress: caches invalidate, no new fetch
//   <p>_rom_addr/cs     byte address and chip select from reader <p>
//   <p>_rom_ok/data     cache hit flag and cached byte for reader <p>
//   sdram_addr/req      word address and request towards SDRAM
//   sdram_ack/dok/data  request accepted, read data valid, read word
module jtbubl_rom_arb #(
  parameter logic [21:0] SUB_OFFSET = 22'h02_0000,
  parameter logic [21:0] MCU_OFFSET = 22'h02_4000
) (
  input  logic        clk24,
  input  logic        rst,
  input  logic        downloading,
  input  logic [17:0] main_rom_addr,
  input  logic        main_rom_cs,
  output logic        main_rom_ok,
  output logic [7:0]  main_rom_data,
  input  logic [14:0] sub_rom_addr,
  input  logic        sub_rom_cs,
  output logic        sub_rom_ok,
  output logic [7:0]  sub_rom_data,
  input  logic [11:0] mcu_rom_addr,
  input  logic        mcu_rom_cs,
  output logic        mcu_rom_ok,
  output logic [7:0]  mcu_rom_data,
  output logic [21:0] sdram_addr,
  output logic        sdram_req,
  input  logic        sdram_ack,
  input  logic        sdram_dok,
  input  logic [15:0] sdram_data
);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA} state_t;

  localparam logic [1:0] P_MAIN = 2'd0;
  localparam logic [1:0] P_SUB  = 2'd1;
  localparam logic [1:0] P_MCU  = 2'd2;

  function automatic logic [1:0] next_port(input logic [1:0] p);
    return (p == P_MCU) ? P_MAIN : p + 2'd1;
  endfunction

  state_t           state_q, state_d;
  logic [1:0]       port_q, port_d;        // port being fetched
  logic [1:0]       last_q, last_d;        // last port served
  logic [17:0]      addr_q, addr_d;        // byte address being fetched
  logic [21:0]      sdram_addr_q, sdram_addr_d;
  logic             discard_q, discard_d;  // download seen during fetch
  logic [2:0]       valid_q, valid_d;
  logic [2:0][17:0] tag_q, tag_d;
  logic [2:0][7:0]  data_q, data_d;

  logic [2:0]       cs_vec, hit, miss;
  logic [2:0][17:0] addr_vec;
  logic [2:0][21:0] word_vec;
  logic [1:0]       cand, sel;
  logic             sel_found, fill;
  logic [7:0]       fill_byte;

  // Cache lookup and SDRAM word address for each port. The offset sums are
  // 22 bits wide on purpose so they wrap instead of carrying out.
  always_comb begin
    cs_vec      = {mcu_rom_cs, sub_rom_cs, main_rom_cs};
    addr_vec[0] = main_rom_addr;
    addr_vec[1] = {3'd0, sub_rom_addr};
    addr_vec[2] = {6'd0, mcu_rom_addr};
    word_vec[0] = {5'd0, main_rom_addr[17:1]};
    word_vec[1] = {8'd0, sub_rom_addr[14:1]} + SUB_OFFSET;
    word_vec[2] = {11'd0, mcu_rom_addr[11:1]} + MCU_OFFSET;
    for (int i = 0; i < 3; i++) begin
      hit[i]  = cs_vec[i] && valid_q[i] && (tag_q[i] == addr_vec[i]);
      miss[i] = cs_vec[i] && !hit[i] && !downloading;
    end
  end

  // Round-robin pick: search starts at the port after the last one served.
  always_comb begin
    sel       = P_MAIN;
    sel_found = 1'b0;
    cand      = next_port(last_q);
    for (int i = 0; i < 3; i++) begin
      if (!sel_found && miss[cand]) begin
        sel       = cand;
        sel_found = 1'b1;
      end
      cand = next_port(cand);
    end
  end

  assign fill_byte = addr_q[0] ? sdram_data[15:8] : sdram_data[7:0];

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk24 or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      port_q       <= P_MAIN;
      last_q       <= P_MCU;
      addr_q       <= '0;
      sdram_addr_q <= '0;
      discard_q    <= 1'b0;
      valid_q      <= '0;
      tag_q        <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      port_q       <= port_d;
      last_q       <= last_d;
      addr_q       <= addr_d;
      sdram_addr_q <= sdram_addr_d;
      discard_q    <= discard_d;
      valid_q      <= valid_d;
      tag_q        <= tag_d;
      data_q       <= data_d;
    end
  end

  // Next-state and cache update.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    port_d       = port_q;
    last_d       = last_q;
    addr_d       = addr_q;
    sdram_addr_d = sdram_addr_q;
    discard_d    = discard_q | downloading;
    valid_d      = valid_q;
    tag_d        = tag_q;
    data_d       = data_q;
    fill         = 1'b0;

    unique case (state_q)
      IDLE: begin
        discard_d = 1'b0;
        if (sel_found) begin
          port_d       = sel;
          addr_d       = addr_vec[sel];
          sdram_addr_d = word_vec[sel];
          state_d      = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (sdram_ack) begin
          // ack and dok together count as ack followed by dok
          fill    = sdram_dok;
          state_d = sdram_dok ? IDLE : WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (sdram_dok) begin
          fill    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (fill) begin
      last_d = port_q;
      // A fetch overlapped by a download completes but leaves the cache alone.
      if (!(discard_q || downloading)) begin
        valid_d[port_q] = 1'b1;
        tag_d[port_q]   = addr_q;
        data_d[port_q]  = fill_byte;
      end
    end

    if (downloading) valid_d = '0;
  end

  // Outputs.
  always_comb begin
    main_rom_ok   = hit[0];
    sub_rom_ok    = hit[1];
    mcu_rom_ok    = hit[2];
    main_rom_data = data_q[0];
    sub_rom_data  = data_q[1];
    mcu_rom_data  = data_q[2];
    sdram_req     = (state_q == WAIT_ACK);
    sdram_addr    = sdram_addr_q;
  end

endmodule
